sbox: RTL and testbench



---
 rtl/sbox_if.sv | 20 ++
 rtl/sbox.sv | 87 ++++++++
 tb/tb_sbox.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sbox_if.sv
// Substitution-box port bundle: column input/valid in, combinational and registered result out.
// Optional SBOX_INV_EN adds the inverse-table select inv_i.
interface sbox_if;
    localparam int unsigned W = 5;

    logic [W-1:0] sbox_i;
    logic         valid_i;
    logic [W-1:0] sbox_o;
    logic [W-1:0] sbox_q_o;
    logic         valid_o;
`ifdef SBOX_INV_EN
    logic         inv_i;

    modport master (output sbox_i, valid_i, inv_i, input sbox_o, sbox_q_o, valid_o);
    modport slave  (input sbox_i, valid_i, inv_i, output sbox_o, sbox_q_o, valid_o);
`else
    modport master (output sbox_i, valid_i, input sbox_o, sbox_q_o, valid_o);
    modport slave  (input sbox_i, valid_i, output sbox_o, sbox_q_o, valid_o);
`endif
endinterface

// File: rtl/sbox.sv
// 5-bit Ascon S-box: combinational lookup plus a valid-tracked registered copy.
// Define SBOX_INV_EN to add inv_i and the inverse table.
module sbox (
    input  logic   clock_i,
    input  logic   resetb_i,
    sbox_if.slave  bus
);
    localparam int unsigned W = 5;

    // Bitsliced chi form; bit4 = x0 ... bit0 = x4.
    function automatic logic [W-1:0] s_fwd(input logic [W-1:0] x);
        logic x0, x1, x2, x3, x4;
        logic t0, t1, t2, t3, t4;
        x0 = x[4]; x1 = x[3]; x2 = x[2]; x3 = x[1]; x4 = x[0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [W-1:0] s_inv(input logic [W-1:0] y);
        logic [W-1:0] r;
        case (y)
            5'h00: r = 5'h14;  5'h01: r = 5'h1A;  5'h02: r = 5'h07;  5'h03: r = 5'h0D;
            5'h04: r = 5'h00;  5'h05: r = 5'h09;  5'h06: r = 5'h0E;  5'h07: r = 5'h12;
            5'h08: r = 5'h0A;  5'h09: r = 5'h06;  5'h0A: r = 5'h1D;  5'h0B: r = 5'h01;
            5'h0C: r = 5'h19;  5'h0D: r = 5'h15;  5'h0E: r = 5'h13;  5'h0F: r = 5'h1E;
            5'h10: r = 5'h18;  5'h11: r = 5'h16;  5'h12: r = 5'h0B;  5'h13: r = 5'h11;
            5'h14: r = 5'h03;  5'h15: r = 5'h05;  5'h16: r = 5'h1C;  5'h17: r = 5'h1F;
            5'h18: r = 5'h17;  5'h19: r = 5'h1B;  5'h1A: r = 5'h04;  5'h1B: r = 5'h08;
            5'h1C: r = 5'h0F;  5'h1D: r = 5'h0C;  5'h1E: r = 5'h10;  default: r = 5'h02;
        endcase
        return r;
    endfunction
`endif

    logic [W-1:0] sbox_c;
    logic [W-1:0] result_d, result_q;
    logic         valid_d, valid_q;

    // Lookup path, independent of clock and reset.
    always_comb begin
        sbox_c = s_fwd(bus.sbox_i);
`ifdef SBOX_INV_EN
        if (bus.inv_i) begin
            sbox_c = s_inv(bus.sbox_i);
        end
`endif
    end

    always_comb begin
        result_d = result_q;
        valid_d  = bus.valid_i;
        if (bus.valid_i) begin
            result_d = sbox_c;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            result_q <= W'(0);
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.sbox_o   = sbox_c;
    assign bus.sbox_q_o = result_q;
    assign bus.valid_o  = valid_q;
endmodule

// File: tb/tb_sbox.sv
// Directed bench for sbox: comb sweep, exhaustive table, reset, pipeline, hold, optional inverse.
module tb_sbox;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [4:0] s_tab [32];
    logic [31:0] seen;

    sbox_if bus ();

    sbox dut (
        .clock_i  (clk),
        .resetb_i (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic step(input logic [4:0] din, input logic vld);
        @(negedge clk);
        bus.sbox_i  = din;
        bus.valid_i = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        seen  = '0;
        s_tab = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                  5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                  5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                  5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
        rst_n       = 1'b0;
        bus.sbox_i  = 5'h00;
        bus.valid_i = 1'b0;
`ifdef SBOX_INV_EN
        bus.inv_i   = 1'b0;
`endif
        #2;
        check("reset_q", bus.sbox_q_o, 5'h00);
        check1("reset_valid", bus.valid_o, 1'b0);

        // Combinational sweep while held in reset
        for (int i = 0; i < 12; i++) begin
            bus.sbox_i = 5'(i);
            #10;
            check($sformatf("comb_%0h", i), bus.sbox_o, s_tab[i]);
        end

        // Reset wins over valid_i
        bus.sbox_i  = 5'h1F;
        bus.valid_i = 1'b1;
        #1;
        check("rst_comb", bus.sbox_o, 5'h17);
        @(posedge clk);
        #1;
        check("rst_q_valid_in", bus.sbox_q_o, 5'h00);
        check1("rst_valid_in", bus.valid_o, 1'b0);
        check("rst_comb_after_edge", bus.sbox_o, 5'h17);

        @(negedge clk);
        rst_n       = 1'b1;
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_q", bus.sbox_q_o, 5'h00);
        check1("post_rst_valid", bus.valid_o, 1'b0);

        // Back-to-back pipeline
        step(5'h03, 1'b1);
        check("pipe_03", bus.sbox_q_o, 5'h14);
        check1("pipe_03_v", bus.valid_o, 1'b1);
        step(5'h14, 1'b1);
        check("pipe_14", bus.sbox_q_o, 5'h00);
        check1("pipe_14_v", bus.valid_o, 1'b1);
        step(5'h1F, 1'b1);
        check("pipe_1f", bus.sbox_q_o, 5'h17);
        check1("pipe_1f_v", bus.valid_o, 1'b1);

        // Hold with valid_i low
        step(5'h05, 1'b0);
        check("hold_05", bus.sbox_q_o, 5'h17);
        check1("hold_05_v", bus.valid_o, 1'b0);
        check("hold_05_comb", bus.sbox_o, 5'h15);
        step(5'h06, 1'b0);
        check("hold_06", bus.sbox_q_o, 5'h17);
        check1("hold_06_v", bus.valid_o, 1'b0);
        check("hold_06_comb", bus.sbox_o, 5'h09);

        // Exhaustive through both paths
        for (int i = 0; i < 32; i++) begin
            step(5'(i), 1'b1);
            check($sformatf("exh_comb_%0h", i), bus.sbox_o, s_tab[i]);
            check($sformatf("exh_q_%0h", i), bus.sbox_q_o, s_tab[i]);
            seen[bus.sbox_o] = 1'b1;
        end
        total++;
        assert (seen === 32'hFFFF_FFFF) else begin
            bad++;
            $error("FAIL bijective observed=%h expected=ffffffff", seen);
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        bus.sbox_i  = 5'h0A;
        bus.valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", bus.sbox_q_o, 5'h00);
        check1("async_rst_v", bus.valid_o, 1'b0);
        check("async_rst_comb", bus.sbox_o, 5'h08);
        @(posedge clk);
        #1;
        check("async_rst_hold_q", bus.sbox_q_o, 5'h00);
        check1("async_rst_hold_v", bus.valid_o, 1'b0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.valid_i = 1'b0;
        step(5'h0A, 1'b1);
        check("resume_q", bus.sbox_q_o, 5'h08);
        check1("resume_v", bus.valid_o, 1'b1);

`ifdef SBOX_INV_EN
        @(negedge clk);
        bus.inv_i   = 1'b1;
        bus.valid_i = 1'b0;
        bus.sbox_i  = 5'h04;
        #1;
        check("inv_04", bus.sbox_o, 5'h00);
        bus.sbox_i = 5'h17;
        #1;
        check("inv_17", bus.sbox_o, 5'h1F);
        bus.sbox_i = 5'h00;
        #1;
        check("inv_00", bus.sbox_o, 5'h14);
        for (int i = 0; i < 32; i++) begin
            bus.sbox_i = s_tab[i];
            #1;
            check($sformatf("roundtrip_%0h", i), bus.sbox_o, 5'(i));
        end
        step(5'h1F, 1'b1);
        check("inv_q_1f", bus.sbox_q_o, 5'h02);
        @(negedge clk);
        bus.inv_i = 1'b0;
        step(5'h1F, 1'b1);
        check("fwd_q_1f", bus.sbox_q_o, 5'h17);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
